// File: rtl/sram_cluster_ctrl.sv
// SRAM cluster controller: sequences one fabric access at a time onto the four
// 8-bit macros A..D. It decodes byte/half/word requests into chip selects,
// a shared write enable and address, per-lane write data, and the select
// pattern for the cluster output mux. Lane map: byte 0 = D ... byte 3 = A.
module sram_cluster_ctrl #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_err,
  output logic              csb_A,
  output logic              csb_B,
  output logic              csb_C,
  output logic              csb_D,
  output logic              web,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        din_A,
  output logic [7:0]        din_B,
  output logic [7:0]        din_C,
  output logic [7:0]        din_D,
  output logic [3:0]        sel_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t          state;
  logic            we_q;
  logic [2:0]      wait_cnt;
  logic [3:0]      csb_q;
  logic [3:0][7:0] din_q;

  // Lane bit i / byte i: 0 = D, 1 = C, 2 = B, 3 = A
  logic [3:0]      dec_lanes;
  logic            dec_err;
  logic [3:0][7:0] dec_bytes;

  // Decode the incoming request into lanes, per-lane write bytes and an error flag
  always_comb begin
    dec_lanes = 4'b0000;
    dec_err   = 1'b0;
    dec_bytes = '0;
    case (req_mode)
      2'b00: begin
        dec_lanes = 4'b0001 << req_addr[1:0];
        dec_bytes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        dec_err   = req_addr[0];
        dec_lanes = req_addr[1] ? 4'b1100 : 4'b0011;
        dec_bytes = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        dec_err   = |req_addr[1:0];
        dec_lanes = 4'b1111;
        dec_bytes = req_wdata;
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Access sequencer: all macro-facing and fabric-facing outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      csb_q     <= 4'b1111;
      web       <= 1'b1;
      sel_out   <= 4'b1111;
      sram_addr <= '0;
      din_q     <= '0;
      wait_cnt  <= 3'd0;
      we_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            if (dec_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state     <= ACCESS;
              csb_q     <= ~dec_lanes;
              web       <= ~req_we;
              sram_addr <= req_addr[ADDR_W+1:2];
              sel_out   <= dec_lanes;
              for (int i = 0; i < 4; i++) begin
                if (req_we && dec_lanes[i]) din_q[i] <= dec_bytes[i];
              end
            end
          end
        end
        ACCESS: begin
          csb_q <= 4'b1111;
          web   <= 1'b1;
          if (we_q || RD_LAT <= 1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= 3'(RD_LAT - 1);
          end
        end
        WAIT: begin
          if (wait_cnt <= 3'd1) begin
            wait_cnt  <= 3'd0;
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign csb_A = csb_q[3];
  assign csb_B = csb_q[2];
  assign csb_C = csb_q[1];
  assign csb_D = csb_q[0];
  assign din_A = din_q[3];
  assign din_B = din_q[2];
  assign din_C = din_q[1];
  assign din_D = din_q[0];

endmodule
